// File: rtl/frame_commit_scheduler.sv
// Frame-synchronous commit of game state to the render path, plus frame tick,
// physics-step divider, frame counter and a sync-loss watchdog.
module frame_commit_scheduler #(
  parameter int unsigned COMMIT_WINDOW = 1024,
  parameter int unsigned STEP_DIV      = 2,
  parameter int unsigned BIRD_Y_INIT   = 240,
  parameter int unsigned BIRD_Y_MAX    = 479,
  parameter int unsigned SYNC_TIMEOUT  = 900000
) (
  input  logic        iClock,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic        iUpdateReq,
  input  logic [9:0]  iBirdYNext,
  input  logic [15:0] iScoreNext,
  output logic        oUpdateAck,
  output logic [9:0]  oBirdY,
  output logic [15:0] oScore,
  output logic        oFrameTick,
  output logic        oPhysicsStep,
  output logic [15:0] oFrameCount,
  output logic        oSyncLost
);

  localparam int unsigned WIN_W = $clog2(COMMIT_WINDOW + 1);
  localparam int unsigned WD_W  = $clog2(SYNC_TIMEOUT + 1);

  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(COMMIT_WINDOW - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(SYNC_TIMEOUT);
  localparam logic [7:0]       DIV_LAST = 8'(STEP_DIV - 1);
  localparam logic [9:0]       Y_MAX    = 10'(BIRD_Y_MAX);
  localparam logic [9:0]       Y_INIT   = 10'(BIRD_Y_INIT);

  typedef enum logic {
    ACTIVE = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic             vs_q;
  logic             vs_fall;
  logic [WIN_W-1:0] win_cnt, win_next;
  logic             commit;
  logic [7:0]       div_cnt;
  logic [WD_W-1:0]  wd_cnt, wd_next;
  logic [9:0]       bird_clamped;

  assign vs_fall      = vs_q & ~iVS;
  assign bird_clamped = (iBirdYNext > Y_MAX) ? Y_MAX : iBirdYNext;
  assign wd_next      = vs_fall           ? '0     :
                        (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

  // A new frame always (re)opens the window, so vs_fall outranks a request
  // sampled in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_next = state;
    win_next   = win_cnt;
    commit     = 1'b0;
    case (state)
      ACTIVE: begin
        if (vs_fall) begin
          state_next = COMMIT;
          win_next   = WIN_LOAD;
        end
      end
      COMMIT: begin
        if (vs_fall) begin
          win_next = WIN_LOAD;
        end else if (iUpdateReq) begin
          commit     = 1'b1;
          state_next = ACTIVE;
        end else if (win_cnt == '0) begin
          state_next = ACTIVE;
        end else begin
          win_next = win_cnt - 1'b1;
        end
      end
      default: state_next = ACTIVE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge iClock) begin
    if (!iRST_n) begin
      state   <= ACTIVE;
      win_cnt <= '0;
      vs_q    <= 1'b1;
    end else begin
      state   <= state_next;
      win_cnt <= win_next;
      vs_q    <= iVS;
    end
  end

  // Render-facing values move only on a commit edge, never mid-frame.
  always_ff @(posedge iClock) begin
    if (!iRST_n) begin
      oBirdY     <= Y_INIT;
      oScore     <= '0;
      oUpdateAck <= 1'b0;
    end else begin
      oUpdateAck <= commit;
      if (commit) begin
        oBirdY <= bird_clamped;
        oScore <= iScoreNext;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (!iRST_n) begin
      oFrameTick   <= 1'b0;
      oPhysicsStep <= 1'b0;
      oFrameCount  <= '0;
      div_cnt      <= '0;
    end else begin
      oFrameTick   <= vs_fall;
      oPhysicsStep <= 1'b0;
      if (vs_fall) begin
        oFrameCount <= oFrameCount + 1'b1;
        if (div_cnt >= DIV_LAST) begin
          div_cnt      <= '0;
          oPhysicsStep <= 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  // Flag is derived from the next count so it drops right after the clearing edge.
  always_ff @(posedge iClock) begin
    if (!iRST_n) begin
      wd_cnt    <= '0;
      oSyncLost <= 1'b0;
    end else begin
      wd_cnt    <= wd_next;
      oSyncLost <= (wd_next == WD_MAX);
    end
  end

endmodule

// File: tb/tb_frame_commit_scheduler.sv
// Scoreboard bench for frame_commit_scheduler: a cycle-indexed window model
// predicts acks and ticks into queues that a monitor drains as the DUT emits them.
module tb_frame_commit_scheduler;

  localparam int W  = 64;
  localparam int SD = 3;
  localparam int YI = 240;
  localparam int YM = 479;
  localparam int T  = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        req = 1'b0;
  logic [9:0]  by = '0;
  logic [15:0] sc = '0;
  logic        ack, tick, step, lost;
  logic [9:0]  bird;
  logic [15:0] score, fcount;

  always #5 clk = ~clk;

  frame_commit_scheduler #(
    .COMMIT_WINDOW(W), .STEP_DIV(SD), .BIRD_Y_INIT(YI),
    .BIRD_Y_MAX(YM), .SYNC_TIMEOUT(T)
  ) dut (
    .iClock(clk), .iRST_n(rst_n), .iVS(vs), .iUpdateReq(req),
    .iBirdYNext(by), .iScoreNext(sc), .oUpdateAck(ack), .oBirdY(bird),
    .oScore(score), .oFrameTick(tick), .oPhysicsStep(step),
    .oFrameCount(fcount), .oSyncLost(lost)
  );

  typedef struct {
    longint      cyc;
    logic [9:0]  bird;
    logic [15:0] score;
  } ack_t;

  typedef struct {
    longint      cyc;
    logic [15:0] count;
    logic        step;
  } tick_t;

  ack_t   ack_q[$];
  tick_t  tick_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;

  // Reference model state: window bounds and watchdog base are absolute cycle numbers.
  bit          live = 1'b0;
  bit          m_vs_prev, committed, m_lost;
  longint      win_start, win_end, base, frames;
  logic [9:0]  m_bird;
  logic [15:0] m_score;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    bit fall;
    if (!rst_n) begin
      live      = 1'b1;
      m_vs_prev = 1'b1;
      win_start = 1;
      win_end   = 0;
      committed = 1'b0;
      frames    = 0;
      m_bird    = 10'(YI);
      m_score   = '0;
      m_lost    = 1'b0;
      base      = cyc + 1;
      ack_q.delete();
      tick_q.delete();
    end else if (live) begin
      fall      = m_vs_prev && !vs;
      m_vs_prev = vs;
      if (fall) begin
        frames++;
        win_start = cyc + 1;
        win_end   = cyc + W;
        committed = 1'b0;
        base      = cyc + 1;
        tick_q.push_back(tick_t'{cyc + 1, 16'(frames), (frames % SD) == 0});
      end else if (req && !committed && cyc >= win_start && cyc <= win_end) begin
        committed = 1'b1;
        m_bird    = (int'(by) > YM) ? 10'(YM) : by;
        m_score   = sc;
        ack_q.push_back(ack_t'{cyc + 1, m_bird, m_score});
      end
      m_lost = (cyc + 1 - base) >= T;
    end
    cyc++;
  end

  always @(negedge clk) begin : monitor
    ack_t  ae;
    tick_t te;
    bit    exp_ack, exp_tick;
    if (live) begin
      exp_ack = (ack_q.size() > 0) && (ack_q[0].cyc == cyc);
      check("update_ack", 64'(ack), 64'(exp_ack));
      if (exp_ack || ack === 1'b1) begin
        if (ack_q.size() > 0) begin
          ae = ack_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(ae.cyc));
          check("ack_bird_y", 64'(bird), 64'(ae.bird));
          check("ack_score", 64'(score), 64'(ae.score));
        end
      end
      exp_tick = (tick_q.size() > 0) && (tick_q[0].cyc == cyc);
      check("frame_tick", 64'(tick), 64'(exp_tick));
      if (exp_tick) begin
        te = tick_q.pop_front();
        check("tick_frame_count", 64'(fcount), 64'(te.count));
        check("physics_step", 64'(step), 64'(te.step));
      end else begin
        check("physics_step_idle", 64'(step), 64'(0));
      end
      check("bird_y", 64'(bird), 64'(m_bird));
      check("score", 64'(score), 64'(m_score));
      check("frame_count", 64'(fcount), 64'(16'(frames)));
      check("sync_lost", 64'(lost), 64'(m_lost));
    end
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (req && ack) req = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic vs_pulse(input int low);
    vs = 1'b0;
    run(low);
    vs = 1'b1;
  endtask

  task automatic rand_cycle();
    if (!req && $urandom_range(0, 60) == 0) begin
      by  = 10'($urandom);
      sc  = 16'($urandom);
      req = 1'b1;
    end
    step_cycle();
  endtask

  initial begin
    int hi, lo;
    // Reset with VS idle, then the first frame.
    rst_n = 1'b0; vs = 1'b1;
    run(10);
    rst_n = 1'b1;
    run(5);
    vs_pulse(4);
    run(20);

    // Request held long before the frame boundary.
    by = 10'd100; sc = 16'd7; req = 1'b1;
    run(5000);
    vs_pulse(4);
    run(50);

    // Request arriving after the window closed waits a frame; clamp and max score.
    vs_pulse(4);
    run(W + 6);
    by = 10'd600; sc = 16'hFFFF; req = 1'b1;
    run(100);
    vs_pulse(4);
    run(20);

    // Nine short frames: window reloads inside COMMIT, step every third frame.
    for (int f = 0; f < 9; f++) begin
      vs_pulse(2);
      run(28);
    end

    // Watchdog expiry and recovery.
    run(T + 5);
    vs_pulse(3);
    run(10);

    // Reset while in COMMIT with a request pending.
    vs = 1'b0;
    step_cycle();
    rst_n = 1'b0; vs = 1'b1; req = 1'b1; by = 10'd50; sc = 16'd9;
    step_cycle();
    rst_n = 1'b1; req = 1'b0;
    run(10);

    // Randomized frames and requests.
    for (int f = 0; f < 150; f++) begin
      hi = $urandom_range(20, 200);
      lo = $urandom_range(1, 8);
      vs = 1'b0;
      for (int i = 0; i < lo; i++) rand_cycle();
      vs = 1'b1;
      for (int i = 0; i < hi; i++) rand_cycle();
    end
    req = 1'b0;
    run(5);

    check("ack_queue_drained", 64'(ack_q.size()), 64'(0));
    check("tick_queue_drained", 64'(tick_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
